// File: rtl/xenyx_defs.sv
// Shared Xenyx-4 control encodings: FSM states, RV32I opcodes, datapath select codes.
// Latency: none (definitions only).
// Backpressure: n/a.
package xenyx_defs;

  // Controller states; the numeric values are visible on the debug state port.
  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEM       = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd5,
    ST_FAULT     = 3'd6
  } state_t;

  // Instruction classes as seen by the FSM.
  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JAL,
    CLS_JALR,
    CLS_SYSTEM,
    CLS_ILLEGAL
  } instr_class_t;

  // RV32I major opcodes.
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  // Immediate formats; the immediate generator decodes the same values.
  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  // Next-PC sources.
  localparam logic [1:0] PC_SRC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_SRC_IMM   = 2'd1;
  localparam logic [1:0] PC_SRC_ALU   = 2'd2;

  // Register writeback sources.
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

endpackage

// File: rtl/ctrl_decoder.sv
// Opcode decoder: instruction class, immediate format, ALU B select and legality.
// Latency: purely combinational.
// Backpressure: none.
module ctrl_decoder
  import xenyx_defs::*;
(
  input  logic [6:0]   opcode,
  output instr_class_t cls,
  output logic [2:0]   imm_sel,
  output logic         alu_src_b,
  output logic         legal
);

  // Opcode lookup; SYSTEM is recognised but not "legal" so the FSM can route it to HALT.
  always_comb begin
    cls       = CLS_ILLEGAL;
    imm_sel   = IMM_I;
    alu_src_b = 1'b0;
    legal     = 1'b0;
    case (opcode)
      OPC_OP: begin
        cls   = CLS_ALU;
        legal = 1'b1;
      end
      OPC_OP_IMM: begin
        cls       = CLS_ALU;
        alu_src_b = 1'b1;
        legal     = 1'b1;
      end
      OPC_LOAD: begin
        cls       = CLS_LOAD;
        alu_src_b = 1'b1;
        legal     = 1'b1;
      end
      OPC_STORE: begin
        cls       = CLS_STORE;
        imm_sel   = IMM_S;
        alu_src_b = 1'b1;
        legal     = 1'b1;
      end
      OPC_BRANCH: begin
        // ALU compares rs1/rs2; target comes from PC+imm.
        cls     = CLS_BRANCH;
        imm_sel = IMM_B;
        legal   = 1'b1;
      end
      OPC_JAL: begin
        cls     = CLS_JAL;
        imm_sel = IMM_J;
        legal   = 1'b1;
      end
      OPC_JALR: begin
        cls       = CLS_JALR;
        alu_src_b = 1'b1;
        legal     = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        cls       = CLS_ALU;
        imm_sel   = IMM_U;
        alu_src_b = 1'b1;
        legal     = 1'b1;
      end
      OPC_SYSTEM: begin
        cls = CLS_SYSTEM;
      end
      default: begin
        cls = CLS_ILLEGAL;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Xenyx-4 multicycle control FSM: sequences fetch/decode/execute/mem/writeback, counts retires.
// Latency: 3-5 cycles per instruction with zero-wait memory, +1 per memory wait cycle.
// Backpressure: mem_req held until mem_ready; a wait of TIMEOUT_CYCLES cycles ends in FAULT.
module multicycle_controller
  import xenyx_defs::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        br_taken,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic [2:0]  imm_sel,
  output logic        alu_src_b,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic        halted,
  output logic        fault,
  output logic [31:0] instret,
  output logic [2:0]  state
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT_CYCLES);

  state_t       state_q, state_d;
  logic [7:0]   wait_cnt_q, wait_cnt_d;
  logic [31:0]  instret_q, instret_d;
  logic         halted_q, halted_d;
  logic         fault_q, fault_d;

  instr_class_t dec_cls;
  logic [2:0]   dec_imm_sel;
  logic         dec_alu_src_b;
  logic         dec_legal;
  logic         hold_dec;
  logic         timed_out;

  // Only the opcode field steers control; the rest of the IR feeds the datapath.
  logic unused_instr_hi;
  assign unused_instr_hi = ^instr[31:7];

  ctrl_decoder u_dec (
    .opcode    (instr[6:0]),
    .cls       (dec_cls),
    .imm_sel   (dec_imm_sel),
    .alu_src_b (dec_alu_src_b),
    .legal     (dec_legal)
  );

  // Next-state and strobe decode; reset masks every strobe in the same cycle.
  always_comb begin
    state_d      = state_q;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = PC_SRC_PLUS4;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    reg_write    = 1'b0;
    wb_sel       = WB_ALU;
    hold_dec     = 1'b0;
    // mem_ready in the limit cycle still completes the request.
    timed_out    = (wait_cnt_q == TIMEOUT_CNT) && !mem_ready;

    case (state_q)
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          state_d  = ST_DECODE;
        end else if (timed_out) begin
          state_d = ST_FAULT;
        end
      end
      ST_DECODE: begin
        hold_dec = 1'b1;
        if (dec_cls == CLS_SYSTEM) state_d = ST_HALT;
        else if (dec_legal)        state_d = ST_EXECUTE;
        else                       state_d = ST_FAULT;
      end
      ST_EXECUTE: begin
        hold_dec = 1'b1;
        case (dec_cls)
          CLS_BRANCH: begin
            pc_write = 1'b1;
            pc_src   = br_taken ? PC_SRC_IMM : PC_SRC_PLUS4;
            state_d  = ST_FETCH;
          end
          CLS_JAL, CLS_JALR: begin
            reg_write = 1'b1;
            wb_sel    = WB_PC4;
            pc_write  = 1'b1;
            pc_src    = (dec_cls == CLS_JAL) ? PC_SRC_IMM : PC_SRC_ALU;
            state_d   = ST_FETCH;
          end
          CLS_LOAD, CLS_STORE: state_d = ST_MEM;
          default:             state_d = ST_WRITEBACK;
        endcase
      end
      ST_MEM: begin
        hold_dec     = 1'b1;
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (dec_cls == CLS_STORE);
        if (mem_ready) begin
          if (dec_cls == CLS_STORE) begin
            pc_write = 1'b1;
            state_d  = ST_FETCH;
          end else begin
            state_d = ST_WRITEBACK;
          end
        end else if (timed_out) begin
          state_d = ST_FAULT;
        end
      end
      ST_WRITEBACK: begin
        hold_dec  = 1'b1;
        reg_write = 1'b1;
        pc_write  = 1'b1;
        wb_sel    = (dec_cls == CLS_LOAD) ? WB_MEM : WB_ALU;
        state_d   = ST_FETCH;
      end
      ST_HALT, ST_FAULT: begin
        state_d = state_q;
      end
      default: begin
        // Unused encoding: park safely.
        state_d = ST_FAULT;
      end
    endcase

    imm_sel   = hold_dec ? dec_imm_sel : IMM_I;
    alu_src_b = hold_dec & dec_alu_src_b;

    if (rst) begin
      ir_write     = 1'b0;
      pc_write     = 1'b0;
      pc_src       = PC_SRC_PLUS4;
      imm_sel      = IMM_I;
      alu_src_b    = 1'b0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      reg_write    = 1'b0;
      wb_sel       = WB_ALU;
    end
  end

  // Wait counter restarts on every state change; retire count follows pc_write; sticky flags.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_d != state_q)          wait_cnt_d = 8'd0;
    else if (mem_req && !mem_ready)  wait_cnt_d = wait_cnt_q + 8'd1;
    instret_d = instret_q + 32'(pc_write);
    halted_d  = halted_q | (state_d == ST_HALT);
    fault_d   = fault_q  | (state_d == ST_FAULT);
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_FETCH;
      wait_cnt_q <= 8'd0;
      instret_q  <= 32'd0;
      halted_q   <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      instret_q  <= instret_d;
      halted_q   <= halted_d;
      fault_q    <= fault_d;
    end
  end

  assign state   = state_q;
  assign instret = instret_q;
  assign halted  = halted_q;
  assign fault   = fault_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-cycle expected outputs queued at drive time, compared mid-cycle.
// Latency: one comparison pair per clock.
// Backpressure: mem_ready wait/timeout patterns driven from the stimulus list.
module tb_multicycle_controller;

  typedef struct packed {
    logic [2:0] st;
    logic [2:0] imm;
    logic       asb;
    logic       req;
    logic       we;
    logic       asel;
    logic       irw;
    logic       pcw;
    logic [1:0] pcs;
    logic       rw;
    logic [1:0] wb;
    logic       h;
    logic       f;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        mem_ready;
  logic        br_taken;
  logic        ir_write;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic [2:0]  imm_sel;
  logic        alu_src_b;
  logic        mem_req;
  logic        mem_we;
  logic        mem_addr_sel;
  logic        reg_write;
  logic [1:0]  wb_sel;
  logic        halted;
  logic        fault;
  logic [31:0] instret;
  logic [2:0]  state;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_instret = 32'd0;
  obs_t        exp_q[$];
  logic [31:0] ins_q[$];

  always #5 clk = ~clk;

  multicycle_controller #(.TIMEOUT_CYCLES(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .instr        (instr),
    .mem_ready    (mem_ready),
    .br_taken     (br_taken),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .pc_src       (pc_src),
    .imm_sel      (imm_sel),
    .alu_src_b    (alu_src_b),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .reg_write    (reg_write),
    .wb_sel       (wb_sel),
    .halted       (halted),
    .fault        (fault),
    .instret      (instret),
    .state        (state)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic obs_t mk(input logic [2:0] st, input logic [2:0] imm, input logic asb,
                              input logic req, input logic we, input logic asel, input logic irw,
                              input logic pcw, input logic [1:0] pcs, input logic rw,
                              input logic [1:0] wb, input logic h, input logic f);
    obs_t o;
    o.st = st; o.imm = imm; o.asb = asb; o.req = req; o.we = we; o.asel = asel;
    o.irw = irw; o.pcw = pcw; o.pcs = pcs; o.rw = rw; o.wb = wb; o.h = h; o.f = f;
    return o;
  endfunction

  function automatic obs_t o_fetch(input logic rdy);
    return mk(3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, rdy, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
  endfunction

  // A state with no strobes: only the held imm_sel / alu_src_b values.
  function automatic obs_t o_st(input logic [2:0] st, input logic [2:0] imm, input logic asb);
    return mk(st, imm, asb, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
  endfunction

  function automatic obs_t get_obs();
    return mk(state, imm_sel, alu_src_b, mem_req, mem_we, mem_addr_sel, ir_write,
              pc_write, pc_src, reg_write, wb_sel, halted, fault);
  endfunction

  // One clock: drive inputs, queue expectations, compare at the falling edge, advance model.
  task automatic cyc(input string tag, input logic r, input logic rdy, input logic br, input obs_t e);
    obs_t e_pop;
    rst = r; mem_ready = rdy; br_taken = br;
    exp_q.push_back(e);
    ins_q.push_back(exp_instret);
    @(negedge clk);
    e_pop = exp_q.pop_front();
    check_val({tag, " outputs"}, 32'(get_obs()), 32'(e_pop));
    check_val({tag, " instret"}, instret, ins_q.pop_front());
    @(posedge clk); #1;
    if (r)          exp_instret = 32'd0;
    else if (e.pcw) exp_instret = exp_instret + 32'd1;
  endtask

  task automatic do_reset();
    rst = 1'b1; mem_ready = 1'b0; br_taken = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_instret = 32'd0;
  endtask

  initial begin
    rst = 1'b1; instr = 32'd0; mem_ready = 1'b0; br_taken = 1'b0;
    @(posedge clk); #1;
    cyc("reset", 1'b1, 1'b1, 1'b0, o_st(3'd0, 3'd0, 1'b0));

    // ADDI x1,x0,5 zero-wait: states 0,1,2,4
    instr = 32'h00500093;
    cyc("addi F", 1'b0, 1'b1, 1'b0, o_fetch(1'b1));
    cyc("addi D", 1'b0, 1'b0, 1'b0, o_st(3'd1, 3'd0, 1'b1));
    cyc("addi E", 1'b0, 1'b0, 1'b0, o_st(3'd2, 3'd0, 1'b1));
    cyc("addi WB", 1'b0, 1'b0, 1'b0, mk(3'd4, 3'd0, 1'b1, 0, 0, 0, 0, 1, 2'd0, 1, 2'd0, 0, 0));

    // LW with 3 wait cycles in MEM: 8 cycles
    instr = 32'h0000A103;
    cyc("lw F", 1'b0, 1'b1, 1'b0, o_fetch(1'b1));
    cyc("lw D", 1'b0, 1'b0, 1'b0, o_st(3'd1, 3'd0, 1'b1));
    cyc("lw E", 1'b0, 1'b0, 1'b0, o_st(3'd2, 3'd0, 1'b1));
    for (int i = 0; i < 3; i++)
      cyc("lw M wait", 1'b0, 1'b0, 1'b0, mk(3'd3, 3'd0, 1'b1, 1, 0, 1, 0, 0, 2'd0, 0, 2'd0, 0, 0));
    cyc("lw M done", 1'b0, 1'b1, 1'b0, mk(3'd3, 3'd0, 1'b1, 1, 0, 1, 0, 0, 2'd0, 0, 2'd0, 0, 0));
    cyc("lw WB", 1'b0, 1'b0, 1'b0, mk(3'd4, 3'd0, 1'b1, 0, 0, 0, 0, 1, 2'd0, 1, 2'd1, 0, 0));

    // BEQ taken, then BNE not taken
    instr = 32'h00000063;
    cyc("beq F", 1'b0, 1'b1, 1'b0, o_fetch(1'b1));
    cyc("beq D", 1'b0, 1'b0, 1'b1, o_st(3'd1, 3'd2, 1'b0));
    cyc("beq E", 1'b0, 1'b0, 1'b1, mk(3'd2, 3'd2, 1'b0, 0, 0, 0, 0, 1, 2'd1, 0, 2'd0, 0, 0));
    instr = 32'h00101063;
    cyc("bne F", 1'b0, 1'b1, 1'b0, o_fetch(1'b1));
    cyc("bne D", 1'b0, 1'b0, 1'b0, o_st(3'd1, 3'd2, 1'b0));
    cyc("bne E", 1'b0, 1'b0, 1'b0, mk(3'd2, 3'd2, 1'b0, 0, 0, 0, 0, 1, 2'd0, 0, 2'd0, 0, 0));

    // SW zero-wait: 4 cycles, pc_write on mem_ready
    instr = 32'h0020A023;
    cyc("sw F", 1'b0, 1'b1, 1'b0, o_fetch(1'b1));
    cyc("sw D", 1'b0, 1'b0, 1'b0, o_st(3'd1, 3'd1, 1'b1));
    cyc("sw E", 1'b0, 1'b0, 1'b0, o_st(3'd2, 3'd1, 1'b1));
    cyc("sw M", 1'b0, 1'b1, 1'b0, mk(3'd3, 3'd1, 1'b1, 1, 1, 1, 0, 1, 2'd0, 0, 2'd0, 0, 0));

    // JAL / JALR: 3 cycles each
    instr = 32'h008000EF;
    cyc("jal F", 1'b0, 1'b1, 1'b0, o_fetch(1'b1));
    cyc("jal D", 1'b0, 1'b0, 1'b0, o_st(3'd1, 3'd4, 1'b0));
    cyc("jal E", 1'b0, 1'b0, 1'b0, mk(3'd2, 3'd4, 1'b0, 0, 0, 0, 0, 1, 2'd1, 1, 2'd2, 0, 0));
    instr = 32'h000080E7;
    cyc("jalr F", 1'b0, 1'b1, 1'b0, o_fetch(1'b1));
    cyc("jalr D", 1'b0, 1'b0, 1'b0, o_st(3'd1, 3'd0, 1'b1));
    cyc("jalr E", 1'b0, 1'b0, 1'b0, mk(3'd2, 3'd0, 1'b1, 0, 0, 0, 0, 1, 2'd2, 1, 2'd2, 0, 0));

    // LUI: U-format immediate
    instr = 32'h123450B7;
    cyc("lui F", 1'b0, 1'b1, 1'b0, o_fetch(1'b1));
    cyc("lui D", 1'b0, 1'b0, 1'b0, o_st(3'd1, 3'd3, 1'b1));
    cyc("lui E", 1'b0, 1'b0, 1'b0, o_st(3'd2, 3'd3, 1'b1));
    cyc("lui WB", 1'b0, 1'b0, 1'b0, mk(3'd4, 3'd3, 1'b1, 0, 0, 0, 0, 1, 2'd0, 1, 2'd0, 0, 0));

    // ADD (R-type) with mem_ready arriving exactly at wait count 4: no fault
    instr = 32'h002081B3;
    for (int i = 0; i < 4; i++)
      cyc("add F wait", 1'b0, 1'b0, 1'b0, o_fetch(1'b0));
    cyc("add F edge", 1'b0, 1'b1, 1'b0, o_fetch(1'b1));
    cyc("add D", 1'b0, 1'b0, 1'b0, o_st(3'd1, 3'd0, 1'b0));
    cyc("add E", 1'b0, 1'b0, 1'b0, o_st(3'd2, 3'd0, 1'b0));
    cyc("add WB", 1'b0, 1'b0, 1'b0, mk(3'd4, 3'd0, 1'b0, 0, 0, 0, 0, 1, 2'd0, 1, 2'd0, 0, 0));

    // Reset held 2 cycles mid-MEM, with mem_ready high in the first one
    instr = 32'h0000A103;
    cyc("rst lw F", 1'b0, 1'b1, 1'b0, o_fetch(1'b1));
    cyc("rst lw D", 1'b0, 1'b0, 1'b0, o_st(3'd1, 3'd0, 1'b1));
    cyc("rst lw E", 1'b0, 1'b0, 1'b0, o_st(3'd2, 3'd0, 1'b1));
    cyc("rst lw M", 1'b0, 1'b0, 1'b0, mk(3'd3, 3'd0, 1'b1, 1, 0, 1, 0, 0, 2'd0, 0, 2'd0, 0, 0));
    cyc("rst cyc1", 1'b1, 1'b1, 1'b0, o_st(3'd3, 3'd0, 1'b0));
    cyc("rst cyc2", 1'b1, 1'b1, 1'b0, o_st(3'd0, 3'd0, 1'b0));
    cyc("rst release", 1'b0, 1'b0, 1'b0, o_fetch(1'b0));

    // ECALL: halted sticky, instret unchanged, mem_ready ignored
    instr = 32'h00000073;
    cyc("ecall F", 1'b0, 1'b1, 1'b0, o_fetch(1'b1));
    cyc("ecall D", 1'b0, 1'b0, 1'b0, o_st(3'd1, 3'd0, 1'b0));
    for (int i = 0; i < 3; i++)
      cyc("halt", 1'b0, 1'b1, 1'b1, mk(3'd5, 3'd0, 1'b0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 1, 0));

    // Illegal opcode 0x7F: FAULT after DECODE, sticky
    do_reset();
    instr = 32'h0000007F;
    cyc("ill F", 1'b0, 1'b1, 1'b0, o_fetch(1'b1));
    cyc("ill D", 1'b0, 1'b0, 1'b0, o_st(3'd1, 3'd0, 1'b0));
    for (int i = 0; i < 3; i++)
      cyc("ill fault", 1'b0, i[0], 1'b0, mk(3'd6, 3'd0, 1'b0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 0, 1));

    // FETCH timeout: mem_ready never arrives
    do_reset();
    instr = 32'h00500093;
    for (int i = 0; i < 5; i++)
      cyc("fto F wait", 1'b0, 1'b0, 1'b0, o_fetch(1'b0));
    for (int i = 0; i < 2; i++)
      cyc("fto fault", 1'b0, 1'b1, 1'b0, mk(3'd6, 3'd0, 1'b0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 0, 1));

    // MEM timeout on a store
    do_reset();
    instr = 32'h0020A023;
    cyc("mto F", 1'b0, 1'b1, 1'b0, o_fetch(1'b1));
    cyc("mto D", 1'b0, 1'b0, 1'b0, o_st(3'd1, 3'd1, 1'b1));
    cyc("mto E", 1'b0, 1'b0, 1'b0, o_st(3'd2, 3'd1, 1'b1));
    for (int i = 0; i < 5; i++)
      cyc("mto M wait", 1'b0, 1'b0, 1'b0, mk(3'd3, 3'd1, 1'b1, 1, 1, 1, 0, 0, 2'd0, 0, 2'd0, 0, 0));
    cyc("mto fault", 1'b0, 1'b1, 1'b0, mk(3'd6, 3'd0, 1'b0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 0, 1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multicycle control FSM for the Xenyx-4 single core. It sequences fetch, decode, execute, memory and writeback over the shared datapath, which includes the PC, IR, ALU, register file and immediate generator. It drives `imm_sel` to the immediate generator and all datapath strobes. It also handshakes with instruction/data memory, detects illegal opcodes and memory timeouts, and counts retired instructions.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum wait cycles for `mem_ready` before FAULT (1..255).
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `instr`  in  32  IR contents; valid from DECODE onward.
- `mem_ready`  in  1  memory completes the current request this cycle.
- `br_taken`  in  1  branch comparator result; valid in EXECUTE.
- `ir_write`  out  1  load IR from memory read data.
- `pc_write`  out  1  update PC.
- `pc_src`  out  2  next-PC select: 0 = PC+4, 1 = PC+imm, 2 = ALU result with bit 0 cleared.
- `imm_sel`  out  3  immediate format: I=0, S=1, B=2, U=3, J=4.
- `alu_src_b`  out  1  ALU B operand: 0 = rs2, 1 = immediate.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  store request.
- `mem_addr_sel`  out  1  memory address: 0 = PC, 1 = ALU result.
- `reg_write`  out  1  register-file write enable.
- `wb_sel`  out  2  writeback source: 0 = ALU, 1 = memory, 2 = PC+4.
- `halted`  out  1  sticky; set on ECALL/EBREAK.
- `fault`  out  1  sticky; set on illegal opcode or memory timeout.
- `instret`  out  32  retired-instruction count.
- `state`  out  3  current state, for debug.

## Operation
- **State encoding:** FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, HALT=5, FAULT=6.
- **FETCH:** assert `mem_req` with `mem_addr_sel`=0.
  - On `mem_ready`, pulse `ir_write` in the same cycle and go to DECODE.
- **DECODE:** decode `instr[6:0]` and drive `imm_sel`.
  - Legal opcodes go to EXECUTE: 0x33, 0x13, 0x03, 0x23, 0x63, 0x6F, 0x67, 0x37, 0x17.
  - 0x73 goes to HALT.
  - Any other opcode goes to FAULT.
- **EXECUTE:**
  - Branch (0x63): `pc_write`=1, `pc_src` = `br_taken` ? 1 : 0, then FETCH.
  - JAL: `reg_write`=1, `wb_sel`=2, `pc_write`=1, `pc_src`=1, then FETCH.
  - JALR: same as JAL but `pc_src`=2.
  - Load/store: `alu_src_b`=1, then MEM.
  - All other opcodes: go to WRITEBACK.
- **MEM:** assert `mem_req` with `mem_addr_sel`=1; `mem_we`=1 for stores.
  - Store: on `mem_ready`, `pc_write`=1 with `pc_src`=0, then FETCH.
  - Load: on `mem_ready`, go to WRITEBACK.
- **WRITEBACK:** `reg_write`=1, `pc_write`=1, `pc_src`=0, then FETCH.
  - `wb_sel` = 1 for loads, otherwise 0.
- **Held signals:** `imm_sel` and `alu_src_b` hold their decoded values in DECODE through WRITEBACK. Both are 0 in FETCH, HALT and FAULT, and for R-type instructions.
- **Retire count:** `instret` increments by 1 on every cycle with `pc_write`=1 and wraps at 2^32.
- **Timeout:** an 8-bit wait counter clears on entry to FETCH or MEM and increments each cycle `mem_req`=1 and `mem_ready`=0.
  - When the counter reaches `TIMEOUT_CYCLES` with `mem_ready` still low, go to FAULT.
  - If `mem_ready` is high in that same cycle, it wins and the transition proceeds normally.
- **Terminal states:** HALT and FAULT are absorbing until `rst`. All strobes are 0 in both. `halted`/`fault` are 1 in HALT/FAULT respectively.

## Timing
- **Reset:** while `rst`=1, all strobes are forced to 0. On the first edge with `rst`=1:
  - `state`=FETCH, counter=0, `instret`=0, `halted`=0, `fault`=0.
  - The first cycle after reset deasserts, `mem_req`=1.
- **Reset mid-operation:** reset wins over any transition, including one completing in the same cycle. No `pc_write` or `reg_write` is issued in a cycle where `rst`=1.
- **Output timing:** outputs are combinational from `state`, `instr`, `br_taken` and `mem_ready`. State and counters are registered.
- **Memory handshake:** `mem_req` stays high until the cycle `mem_ready` is sampled high; the request completes in that cycle. `mem_ready` is ignored outside FETCH and MEM.
- **Cycles per instruction with zero-wait memory:**
  - ALU, LUI, AUIPC, store: 4.
  - Load: 5.
  - Branch, JAL, JALR: 3.
  - Each memory wait cycle adds 1.

## Structure
- **Shared package `xenyx_defs`:**
  - state encodings.
  - RV32I opcode constants.
  - `imm_sel`, `pc_src` and `wb_sel` codes.
  - The immediate generator consumes the same `imm_sel` codes.
- **Sub-module `ctrl_decoder`:** combinational. Maps opcode to instruction class, `imm_sel`, `alu_src_b` and `legal`.
- **Top FSM:** state register, wait counter and `instret`.

## Test plan
- **Reset:** hold `rst` 2 cycles mid-MEM, then release → `state`=0, `instret`=0, no `reg_write` pulse, `mem_req`=1 on the next cycle.
- **ADDI x1,x0,5 (0x00500093), zero-wait memory** → states 0,1,2,4; `imm_sel`=0; `alu_src_b`=1; `reg_write` in cycle 4; `instret`=1.
- **LW with `mem_ready` delayed 3 cycles in MEM** → 8 cycles total; `wb_sel`=1 in WRITEBACK. Then BEQ with `br_taken`=1 → `imm_sel`=2, `pc_src`=1 in EXECUTE.
- **JAL (opcode 0x6F)** → `imm_sel`=4, `wb_sel`=2, `reg_write`=1 and `pc_write`=1 in the same cycle, 3 cycles total.
- **Opcode 0x7F** → FAULT after DECODE, `fault`=1 sticky. Separately, ECALL (0x00000073) → `halted`=1, `instret` unchanged.
- **`mem_ready` held low in FETCH with `TIMEOUT_CYCLES`=4** → FAULT after 4 wait cycles. Separately, assert `mem_ready` exactly on wait count 4 → proceeds to DECODE with no fault.
